// File: rtl/bpf_buffer_ctrl.sv
// bpf_buffer_ctrl
//   Ownership controller for three packet buffers (ping/pang/pong) shared by a
//   snooper, a CPU filter and a forwarder. Each buffer moves through
//   FREE -> SN -> READY -> CPU -> (ACC -> FWD | FREE) -> FREE. Two small FIFOs
//   keep arrival order: ready_q (snoop-completion order) feeds the CPU and
//   acc_q (accept order) feeds the forwarder.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   sn_done, cpu_acc, cpu_rej,    single-cycle event pulses from the agents
//   fwd_done
//   sn_sel, cpu_sel, fwd_sel      buffer held by each agent (00 none, 01 ping,
//                                 10 pang, 11 pong), registered
//   ping_sel, pang_sel, pong_sel  agent holding each buffer (00 none,
//                                 01 snooper, 10 CPU, 11 forwarder)
//   proto_err                     sticky protocol-violation flag
//   acc_cnt, rej_cnt              saturating accept/reject counters
//
// Build option
//   BUF_CTRL_STATS_EN  when defined, acc_cnt/rej_cnt count applied accepts and
//                      rejects; otherwise both are tied to zero.
module bpf_buffer_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sn_done,
  input  logic                 cpu_acc,
  input  logic                 cpu_rej,
  input  logic                 fwd_done,
  output logic [1:0]           sn_sel,
  output logic [1:0]           cpu_sel,
  output logic [1:0]           fwd_sel,
  output logic [1:0]           ping_sel,
  output logic [1:0]           pang_sel,
  output logic [1:0]           pong_sel,
  output logic                 proto_err,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic [CNT_WIDTH-1:0] rej_cnt
);

  typedef enum logic [2:0] {
    B_FREE, B_SN, B_READY, B_CPU, B_ACC, B_FWD
  } buf_st_e;

  buf_st_e    st_q [3];
  buf_st_e    st_d [3];
  logic [1:0] rdy_q [3];
  logic [1:0] rdy_d [3];
  logic [1:0] rdy_cnt_q, rdy_cnt_d;
  logic [1:0] accq_q [3];
  logic [1:0] accq_d [3];
  logic [1:0] accq_cnt_q, accq_cnt_d;
  logic [1:0] sn_sel_q, sn_sel_d;
  logic [1:0] cpu_sel_q, cpu_sel_d;
  logic [1:0] fwd_sel_q, fwd_sel_d;
  logic       proto_err_q, proto_err_d;

  logic       sn_act, cpu_act, do_acc, do_rej, fwd_act;
  logic       sn_claim, cpu_claim, fwd_claim;
  logic [1:0] sn_claim_id;

  function automatic logic [1:0] agent_of(buf_st_e s);
    case (s)
      B_SN:    agent_of = 2'b01;
      B_CPU:   agent_of = 2'b10;
      B_FWD:   agent_of = 2'b11;
      default: agent_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    st_d        = st_q;
    rdy_d       = rdy_q;
    rdy_cnt_d   = rdy_cnt_q;
    accq_d      = accq_q;
    accq_cnt_d  = accq_cnt_q;
    sn_sel_d    = sn_sel_q;
    cpu_sel_d   = cpu_sel_q;
    fwd_sel_d   = fwd_sel_q;

    sn_act    = sn_done  && (sn_sel_q  != 2'b00);
    cpu_act   = (cpu_acc || cpu_rej) && (cpu_sel_q != 2'b00);
    do_rej    = cpu_act && cpu_rej;
    do_acc    = cpu_act && cpu_acc && !cpu_rej;
    fwd_act   = fwd_done && (fwd_sel_q != 2'b00);

    proto_err_d = proto_err_q
                | (sn_done && (sn_sel_q == 2'b00))
                | ((cpu_acc || cpu_rej) && (cpu_sel_q == 2'b00))
                | (cpu_acc && cpu_rej)
                | (fwd_done && (fwd_sel_q == 2'b00));

    // Claims look only at registered state, so a buffer released this edge
    // cannot be re-claimed before the next one.
    sn_claim    = 1'b0;
    sn_claim_id = 2'b00;
    if (sn_sel_q == 2'b00) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!sn_claim && st_q[i] == B_FREE) begin
          sn_claim    = 1'b1;
          sn_claim_id = 2'(i + 1);
        end
      end
    end
    cpu_claim = (cpu_sel_q == 2'b00) && (rdy_cnt_q  != 2'b00);
    fwd_claim = (fwd_sel_q == 2'b00) && (accq_cnt_q != 2'b00);

    if (sn_act)        sn_sel_d = 2'b00;
    else if (sn_claim) sn_sel_d = sn_claim_id;
    if (cpu_act)        cpu_sel_d = 2'b00;
    else if (cpu_claim) cpu_sel_d = rdy_q[0];
    if (fwd_act)        fwd_sel_d = 2'b00;
    else if (fwd_claim) fwd_sel_d = accq_q[0];

    // Each event touches a buffer in a distinct state, so at most one of
    // these updates can hit any given buffer in one cycle.
    for (int unsigned i = 0; i < 3; i++) begin
      if (sn_act    && sn_sel_q    == 2'(i + 1)) st_d[i] = B_READY;
      if (sn_claim  && sn_claim_id == 2'(i + 1)) st_d[i] = B_SN;
      if (cpu_claim && rdy_q[0]    == 2'(i + 1)) st_d[i] = B_CPU;
      if (do_acc    && cpu_sel_q   == 2'(i + 1)) st_d[i] = B_ACC;
      if (do_rej    && cpu_sel_q   == 2'(i + 1)) st_d[i] = B_FREE;
      if (fwd_claim && accq_q[0]   == 2'(i + 1)) st_d[i] = B_FWD;
      if (fwd_act   && fwd_sel_q   == 2'(i + 1)) st_d[i] = B_FREE;
    end

    // Shift-register FIFOs: pop first, then push at the post-pop tail.
    if (cpu_claim) begin
      rdy_d[0]  = rdy_q[1];
      rdy_d[1]  = rdy_q[2];
      rdy_d[2]  = 2'b00;
      rdy_cnt_d = rdy_cnt_q - 2'd1;
    end
    if (sn_act) begin
      rdy_d[rdy_cnt_d] = sn_sel_q;
      rdy_cnt_d        = rdy_cnt_d + 2'd1;
    end
    if (fwd_claim) begin
      accq_d[0]  = accq_q[1];
      accq_d[1]  = accq_q[2];
      accq_d[2]  = 2'b00;
      accq_cnt_d = accq_cnt_q - 2'd1;
    end
    if (do_acc) begin
      accq_d[accq_cnt_d] = cpu_sel_q;
      accq_cnt_d         = accq_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= '{default: B_FREE};
      rdy_q       <= '{default: 2'b00};
      rdy_cnt_q   <= '0;
      accq_q      <= '{default: 2'b00};
      accq_cnt_q  <= '0;
      sn_sel_q    <= '0;
      cpu_sel_q   <= '0;
      fwd_sel_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      rdy_q       <= rdy_d;
      rdy_cnt_q   <= rdy_cnt_d;
      accq_q      <= accq_d;
      accq_cnt_q  <= accq_cnt_d;
      sn_sel_q    <= sn_sel_d;
      cpu_sel_q   <= cpu_sel_d;
      fwd_sel_q   <= fwd_sel_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign sn_sel    = sn_sel_q;
  assign cpu_sel   = cpu_sel_q;
  assign fwd_sel   = fwd_sel_q;
  assign ping_sel  = agent_of(st_q[0]);
  assign pang_sel  = agent_of(st_q[1]);
  assign pong_sel  = agent_of(st_q[2]);
  assign proto_err = proto_err_q;

`ifdef BUF_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0] rej_cnt_q, rej_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    rej_cnt_d = rej_cnt_q;
    if (do_acc && acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
    if (do_rej && rej_cnt_q != '1) rej_cnt_d = rej_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign acc_cnt = acc_cnt_q;
  assign rej_cnt = rej_cnt_q;
`else
  assign acc_cnt = '0;
  assign rej_cnt = '0;
`endif

endmodule

// File: tb/tb_bpf_buffer_ctrl.sv
// Directed bench for bpf_buffer_ctrl. Each step drives one cycle of event
// pulses, queues the expected post-edge outputs and checks them 1 ns after
// the rising edge.
module tb_bpf_buffer_ctrl;

`ifdef BUF_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sn_done = 1'b0, cpu_acc = 1'b0, cpu_rej = 1'b0, fwd_done = 1'b0;
  logic [1:0]  sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel;
  logic        proto_err;
  logic [31:0] acc_cnt, rej_cnt;

  bpf_buffer_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .sn_done(sn_done), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej), .fwd_done(fwd_done),
    .sn_sel(sn_sel), .cpu_sel(cpu_sel), .fwd_sel(fwd_sel),
    .ping_sel(ping_sel), .pang_sel(pang_sel), .pong_sel(pong_sel),
    .proto_err(proto_err), .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [12:0] snap;
    logic [63:0] cnts;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  function automatic logic [31:0] stat(int unsigned v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic expect_out(input string tag,
                            input logic [1:0] sn, cpu, fwd, pi, pa, po,
                            input logic e, input int unsigned a, r);
    exp_t x;
    x.tag  = tag;
    x.snap = {sn, cpu, fwd, pi, pa, po, e};
    x.cnts = {stat(a), stat(r)};
    sbq.push_back(x);
  endtask

  task automatic check_out();
    exp_t        x;
    logic [12:0] got;
    logic [63:0] gotc;
    n_tot++;
    assert (sbq.size() != 0) n_pass++;
    else $error("FAIL scoreboard_empty got %0d want >0", sbq.size());
    if (sbq.size() != 0) begin
      x    = sbq.pop_front();
      got  = {sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel, proto_err};
      gotc = {acc_cnt, rej_cnt};
      n_tot++;
      assert (got === x.snap) n_pass++;
      else $error("FAIL %s sels{sn,cpu,fwd,pi,pa,po,err} got %b want %b", x.tag, got, x.snap);
      n_tot++;
      assert (gotc === x.cnts) n_pass++;
      else $error("FAIL %s_cnt {acc,rej} got %h want %h", x.tag, gotc, x.cnts);
    end
  endtask

  task automatic step(input string tag, input logic sd, ca, cr, fd,
                      input logic [1:0] sn, cpu, fwd, pi, pa, po,
                      input logic e, input int unsigned a, r);
    expect_out(tag, sn, cpu, fwd, pi, pa, po, e, a, r);
    sn_done = sd; cpu_acc = ca; cpu_rej = cr; fwd_done = fd;
    @(posedge clk);
    #1;
    sn_done = 1'b0; cpu_acc = 1'b0; cpu_rej = 1'b0; fwd_done = 1'b0;
    check_out();
  endtask

  initial begin
    #2;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_out();
    #10 rst_n = 1'b1;

    //    tag          sd ca cr fd  sn cpu fwd pi pa po err acc rej
    step("claim_ping",  0, 0, 0, 0,  1, 0, 0,  1, 0, 0, 0,  0, 0);
    step("idle2",       0, 0, 0, 0,  1, 0, 0,  1, 0, 0, 0,  0, 0);
    step("sn_done1",    1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0);
    step("handover",    0, 0, 0, 0,  2, 1, 0,  2, 1, 0, 0,  0, 0);
    step("idle5",       0, 0, 0, 0,  2, 1, 0,  2, 1, 0, 0,  0, 0);
    step("acc_ping",    0, 1, 0, 0,  2, 0, 0,  0, 1, 0, 0,  1, 0);
    step("fwd_ping",    0, 0, 0, 0,  2, 0, 1,  3, 1, 0, 0,  1, 0);
    step("idle8",       0, 0, 0, 0,  2, 0, 1,  3, 1, 0, 0,  1, 0);
    step("fwd_done1",   0, 0, 0, 1,  2, 0, 0,  0, 1, 0, 0,  1, 0);
    step("idle10",      0, 0, 0, 0,  2, 0, 0,  0, 1, 0, 0,  1, 0);
    // ordering: pang then ping complete snooping, CPU and forwarder follow
    step("sn_done_pa",  1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 0);
    step("cpu_pang",    0, 0, 0, 0,  1, 2, 0,  1, 2, 0, 0,  1, 0);
    step("sn_done_pi",  1, 0, 0, 0,  0, 2, 0,  0, 2, 0, 0,  1, 0);
    step("claim_pong",  0, 0, 0, 0,  3, 2, 0,  0, 2, 1, 0,  1, 0);
    step("acc_pang",    0, 1, 0, 0,  3, 0, 0,  0, 0, 1, 0,  2, 0);
    step("order_2nd",   0, 0, 0, 0,  3, 1, 2,  2, 3, 1, 0,  2, 0);
    step("acc_ping2",   0, 1, 0, 0,  3, 0, 2,  0, 3, 1, 0,  3, 0);
    step("multi_evt",   1, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0,  3, 0);
    step("triple_clm",  0, 0, 0, 0,  2, 3, 1,  3, 1, 2, 0,  3, 0);
    // reject path
    step("rej_pong",    0, 0, 1, 0,  2, 0, 1,  3, 1, 0, 0,  3, 1);
    step("fwd_done2",   0, 0, 0, 1,  2, 0, 0,  0, 1, 0, 0,  3, 1);
    // protocol errors and back-pressure
    step("err_fwd",     0, 0, 0, 1,  2, 0, 0,  0, 1, 0, 1,  3, 1);
    step("bp_done1",    1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1,  3, 1);
    step("bp_claim1",   0, 0, 0, 0,  1, 2, 0,  1, 2, 0, 1,  3, 1);
    step("bp_done2",    1, 0, 0, 0,  0, 2, 0,  0, 2, 0, 1,  3, 1);
    step("bp_claim2",   0, 0, 0, 0,  3, 2, 0,  0, 2, 1, 1,  3, 1);
    step("bp_done3",    1, 0, 0, 0,  0, 2, 0,  0, 2, 0, 1,  3, 1);
    step("bp_stall1",   0, 0, 0, 0,  0, 2, 0,  0, 2, 0, 1,  3, 1);
    step("bp_stall2",   0, 0, 0, 0,  0, 2, 0,  0, 2, 0, 1,  3, 1);
    step("acc_and_rej", 0, 1, 1, 0,  0, 0, 0,  0, 0, 0, 1,  3, 2);
    step("bp_release",  0, 0, 0, 0,  2, 1, 0,  2, 1, 0, 1,  3, 2);
    step("rej_ping",    0, 0, 1, 0,  2, 0, 0,  0, 1, 0, 1,  3, 3);
    step("cpu_pong",    0, 0, 0, 0,  2, 3, 0,  0, 1, 2, 1,  3, 3);

    // asynchronous reset in mid-operation
    rst_n = 1'b0;
    #1;
    expect_out("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_out();
    #2 rst_n = 1'b1;
    step("post_reset",  0, 0, 0, 0,  1, 0, 0,  1, 0, 0, 0,  0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
